// File: rtl/alu_share_pkg.sv
// Shared types and sizes for the two-requester ALU time-share controller.
package alu_share_pkg;

    localparam int DATA_W  = 4;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } ctrl_state_e;

endpackage

// File: rtl/alu4bit.sv
// Combinational 4-bit ALU: ADD/SUB/AND/OR with carry (borrow on SUB).
module alu4bit
    import alu_share_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           sel,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide = '0;
        case (sel)
            ADD:     wide = {1'b0, a} + {1'b0, b};
            // 5-bit subtract: the top bit is the borrow, set iff a < b
            SUB:     wide = {1'b0, a} - {1'b0, b};
            AND:     wide = {1'b0, a & b};
            OR:      wide = {1'b0, a | b};
            default: wide = '0;
        endcase
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin scheduler time-sharing one alu4bit between two valid/ready
// requesters, one op in flight, tagged response channel and per-client counters.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [DATA_W-1:0]  req0_b,
    input  logic [1:0]         req0_sel,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [DATA_W-1:0]  req1_b,
    input  logic [1:0]         req1_sel,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [DATA_W-1:0]  rsp_result,
    output logic               rsp_carry,
    output logic               busy,
    output logic [CNT_W-1:0]   done_cnt0,
    output logic [CNT_W-1:0]   done_cnt1
);

    // state | meaning
    // IDLE  | arbitrate; req_ready asserted combinationally for the grantee
    // EXEC  | ALU driven from captured operands; result registered at edge
    // RESP  | response held until rsp_ready, then count and rotate priority

    ctrl_state_e       state;
    logic              rr_ptr;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    alu_op_e           op_sel;
    logic              op_id;

    logic              grant;
    logic              grant_vld;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    always_comb begin
        grant     = 1'b0;
        grant_vld = 1'b0;
        if (req_valid == 2'b11) begin
            grant     = rr_ptr;
            grant_vld = 1'b1;
        end else if (req_valid[0]) begin
            grant     = 1'b0;
            grant_vld = 1'b1;
        end else if (req_valid[1]) begin
            grant     = 1'b1;
            grant_vld = 1'b1;
        end
    end

    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && grant_vld)
            req_ready = grant ? 2'b10 : 2'b01;
    end

    assign busy = (state != IDLE);

    alu4bit u_alu (
        .a      (op_a),
        .b      (op_b),
        .sel    (op_sel),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= ADD;
            op_id      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            done_cnt0  <= '0;
            done_cnt1  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        op_a   <= grant ? req1_a : req0_a;
                        op_b   <= grant ? req1_b : req0_b;
                        op_sel <= alu_op_e'(grant ? req1_sel : req0_sel);
                        op_id  <= grant;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_carry  <= alu_carry;
                    rsp_id     <= op_id;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_id)
                            done_cnt1 <= done_cnt1 + CNT_W'(1);
                        else
                            done_cnt0 <= done_cnt0 + CNT_W'(1);
                        // the requester just served drops to lower priority
                        rr_ptr <= ~rsp_id;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl; a second instance with CNT_W=2 checks counter wrap.
module tb_alu_share_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_sel, req1_sel;
    logic       rsp_ready;

    logic [1:0] req_ready, req_ready2;
    logic       rsp_valid, rsp_id, rsp_carry, busy;
    logic       rsp_valid2, rsp_id2, rsp_carry2, busy2;
    logic [3:0] rsp_result, rsp_result2;
    logic [7:0] done_cnt0, done_cnt1;
    logic [1:0] w_cnt0, w_cnt1;

    int total = 0;
    int bad   = 0;
    int exp_c0, exp_c1;

    always #5 clk = ~clk;

    alu_share_ctrl #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .busy(busy),
        .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    alu_share_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_id(rsp_id2),
        .rsp_result(rsp_result2), .rsp_carry(rsp_carry2), .busy(busy2),
        .done_cnt0(w_cnt0), .done_cnt1(w_cnt1)
    );

    typedef struct {
        logic       id;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] sel;
        logic [3:0] res;
        logic       cy;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_c0 = 0;
        exp_c1 = 0;
    endtask

    task automatic set_req(input logic id, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] sel);
        if (id) begin
            req1_a = a; req1_b = b; req1_sel = sel;
        end else begin
            req0_a = a; req0_b = b; req0_sel = sel;
        end
    endtask

    // Full op on an idle DUT with the other port expected idle, rsp_ready=1 in RESP.
    task automatic quick_op(input logic id, input string tag);
        req_valid = id ? 2'b10 : 2'b01;
        settle();
        chk({tag, "_ready"}, int'(req_ready), id ? 2 : 1);
        step();
        req_valid = 2'b00;
        step();
        chk({tag, "_rsp_valid"}, int'(rsp_valid), 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        if (id) exp_c1++; else exp_c0++;
    endtask

    initial begin
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        req0_a = 0; req0_b = 0; req0_sel = 0;
        req1_a = 0; req1_b = 0; req1_sel = 0;

        vecs[0] = '{1'b0, 4'h7, 4'h9, 2'b00, 4'h0, 1'b1};
        vecs[1] = '{1'b1, 4'h3, 4'h5, 2'b01, 4'hE, 1'b1};
        vecs[2] = '{1'b1, 4'h5, 4'h3, 2'b01, 4'h2, 1'b0};
        vecs[3] = '{1'b1, 4'hC, 4'hA, 2'b10, 4'h8, 1'b0};
        vecs[4] = '{1'b0, 4'h5, 4'hA, 2'b11, 4'hF, 1'b0};
        vecs[5] = '{1'b1, 4'hF, 4'h1, 2'b00, 4'h0, 1'b1};
        vecs[6] = '{1'b0, 4'h4, 4'h4, 2'b01, 4'h0, 1'b0};

        do_reset();
        settle();
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_result", int'(rsp_result), 0);
        chk("rst_rsp_carry", int'(rsp_carry), 0);
        chk("rst_cnt0", int'(done_cnt0), 0);
        chk("rst_cnt1", int'(done_cnt1), 0);

        // table-driven single-requester ops
        for (int i = 0; i < 7; i++) begin
            set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sel);
            req_valid = vecs[i].id ? 2'b10 : 2'b01;
            settle();
            chk($sformatf("v%0d_ready", i), int'(req_ready), vecs[i].id ? 2 : 1);
            step();
            req_valid = 2'b00;
            settle();
            chk($sformatf("v%0d_exec_busy", i), int'(busy), 1);
            chk($sformatf("v%0d_exec_rspv", i), int'(rsp_valid), 0);
            step();
            chk($sformatf("v%0d_rsp_valid", i), int'(rsp_valid), 1);
            chk($sformatf("v%0d_rsp_id", i), int'(rsp_id), int'(vecs[i].id));
            chk($sformatf("v%0d_result", i), int'(rsp_result), int'(vecs[i].res));
            chk($sformatf("v%0d_carry", i), int'(rsp_carry), int'(vecs[i].cy));
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            if (vecs[i].id) exp_c1++; else exp_c0++;
            chk($sformatf("v%0d_rspv_clr", i), int'(rsp_valid), 0);
            chk($sformatf("v%0d_cnt0", i), int'(done_cnt0), exp_c0);
            chk($sformatf("v%0d_cnt1", i), int'(done_cnt1), exp_c1);
        end

        // round robin with both valid held and rsp_ready high
        do_reset();
        set_req(1'b0, 4'h1, 4'h2, 2'b00);
        set_req(1'b1, 4'h8, 4'h1, 2'b11);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("rr%0d_ready", k), int'(req_ready), (k % 2) ? 2 : 1);
            step();
            chk($sformatf("rr%0d_exec_ready", k), int'(req_ready), 0);
            step();
            chk($sformatf("rr%0d_rsp_valid", k), int'(rsp_valid), 1);
            chk($sformatf("rr%0d_rsp_id", k), int'(rsp_id), k % 2);
            chk($sformatf("rr%0d_result", k), int'(rsp_result), (k % 2) ? 9 : 3);
            step();
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        settle();
        chk("rr_cnt0", int'(done_cnt0), 2);
        chk("rr_cnt1", int'(done_cnt1), 2);
        chk("rr_busy_end", int'(busy), 0);
        exp_c0 = 2;
        exp_c1 = 2;

        // response stall: req1 waits while the req0 response is held
        set_req(1'b0, 4'h9, 4'h2, 2'b01);
        req_valid = 2'b01;
        settle();
        chk("st_ready0", int'(req_ready), 1);
        step();
        req_valid = 2'b10;
        step();
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("st%0d_rspv", k), int'(rsp_valid), 1);
            chk($sformatf("st%0d_result", k), int'(rsp_result), 7);
            chk($sformatf("st%0d_carry", k), int'(rsp_carry), 0);
            chk($sformatf("st%0d_id", k), int'(rsp_id), 0);
            chk($sformatf("st%0d_ready", k), int'(req_ready), 0);
            chk($sformatf("st%0d_busy", k), int'(busy), 1);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_c0++;
        settle();
        chk("st_rspv_clr", int'(rsp_valid), 0);
        chk("st_cnt0", int'(done_cnt0), exp_c0);
        chk("st_next_grant", int'(req_ready), 2);
        step();
        req_valid = 2'b00;
        step();
        chk("st_r1_id", int'(rsp_id), 1);
        chk("st_r1_result", int'(rsp_result), 9);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // reset during EXEC
        set_req(1'b1, 4'h1, 4'h1, 2'b00);
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        chk("rx_busy", int'(busy), 0);
        chk("rx_rspv", int'(rsp_valid), 0);
        chk("rx_cnt0", int'(done_cnt0), 0);
        chk("rx_cnt1", int'(done_cnt1), 0);
        step();
        step();
        chk("rx_no_rsp", int'(rsp_valid), 0);
        req_valid = 2'b11;
        settle();
        chk("rx_grant0", int'(req_ready), 1);

        // reset during RESP (request above is accepted, then reset in RESP)
        step();
        req_valid = 2'b00;
        step();
        chk("rr_in_resp", int'(rsp_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        chk("rr_busy", int'(busy), 0);
        chk("rr_rspv", int'(rsp_valid), 0);
        chk("rr_cnt0", int'(done_cnt0), 0);
        chk("rr_cnt1", int'(done_cnt1), 0);
        req_valid = 2'b11;
        settle();
        chk("rr_grant0", int'(req_ready), 1);
        req_valid = 2'b00;
        step();

        // counter wrap on the CNT_W=2 instance
        do_reset();
        set_req(1'b0, 4'h2, 4'h3, 2'b00);
        for (int k = 0; k < 5; k++) quick_op(1'b0, $sformatf("wr%0d", k));
        settle();
        chk("wr_cnt0_w2", int'(w_cnt0), 1);
        chk("wr_cnt1_w2", int'(w_cnt1), 0);
        chk("wr_cnt0_w8", int'(done_cnt0), exp_c0);
        chk("wr_cnt1_w8", int'(done_cnt1), exp_c1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
